// File: rtl/apple_dma_master_if.sv
`default_nettype none
// ============================================================================
// Module      : apple_dma_master_if
// Description : Single-beat request/response handshake between internal
//               logic (master) and the Apple II DMA bus initiator (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface apple_dma_master_if;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        req_wr;
    logic [7:0]  req_data;
    logic        resp_valid;
    logic [7:0]  resp_data;

    modport master (
        output req_valid, req_addr, req_wr, req_data,
        input  req_ready, resp_valid, resp_data
    );

    modport slave (
        input  req_valid, req_addr, req_wr, req_data,
        output req_ready, resp_valid, resp_data
    );
endinterface
`default_nettype wire

// File: rtl/apple_dma_master.sv
`default_nettype none
// ============================================================================
// Module      : apple_dma_master
// Description : Apple II bus initiator. Arbitrates via DMA IN/OUT and runs
//               phi0-aligned single-beat read/write cycles for internal logic.
//               Optional macro A2_DMA_RDY_STALL_EN: reads stall while RDY low.
// Revision    : 1.0 - initial release
// ============================================================================
module apple_dma_master #(
    parameter int MAX_BURST     = 8,
    parameter int WR_DATA_DELAY = 10,
    parameter int WR_DATA_HOLD  = 2
) (
    input  wire               clk_logic,
    input  wire               reset,
    input  wire               phi1_posedge,
    input  wire               phi1_negedge,
    input  wire               a2_dma_in_n,
    input  wire               a2_rdy_n,
    input  wire        [7:0]  a2_d_i,
    apple_dma_master_if.slave req_bus,
    output logic              a2_dma_out_n,
    output logic       [15:0] a2_addr_o,
    output logic              a2_addr_oe,
    output logic              a2_rw_n_o,
    output logic       [7:0]  a2_data_o,
    output logic              a2_data_oe,
    output logic              busy
);

    localparam logic [7:0] c_max_burst = 8'(MAX_BURST);
    localparam logic [7:0] c_wr_delay  = 8'(WR_DATA_DELAY);
    localparam logic [7:0] c_wr_hold   = 8'(WR_DATA_HOLD);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARM     = 2'd1,
        S_CYCLE   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t      r_state,     w_state;
    logic [15:0] r_lat_addr,  w_lat_addr;
    logic        r_lat_wr,    w_lat_wr;
    logic [7:0]  r_lat_data,  w_lat_data;
    logic [7:0]  r_burst_cnt, w_burst_cnt;
    logic [7:0]  r_wcnt,      w_wcnt;
    logic [7:0]  r_hold_cnt,  w_hold_cnt;
    logic        r_req_ready, w_req_ready;
    logic        r_resp_valid, w_resp_valid;
    logic [7:0]  r_resp_data, w_resp_data;
    logic        r_dma_out_n, w_dma_out_n;
    logic [15:0] r_addr_o,    w_addr_o;
    logic        r_addr_oe,   w_addr_oe;
    logic        r_rw_n,      w_rw_n;
    logic [7:0]  r_data_o,    w_data_o;
    logic        r_data_oe,   w_data_oe;
    logic        r_busy;
    logic        w_stall;
    logic        w_burst_more;

`ifdef A2_DMA_RDY_STALL_EN
    assign w_stall = !r_lat_wr && !a2_rdy_n;
`else
    logic w_unused_rdy;
    assign w_unused_rdy = a2_rdy_n;
    assign w_stall      = 1'b0;
`endif

    assign w_burst_more = ({1'b0, r_burst_cnt} + 9'd1) < {1'b0, c_max_burst};

    always_comb begin
        w_state      = r_state;
        w_lat_addr   = r_lat_addr;
        w_lat_wr     = r_lat_wr;
        w_lat_data   = r_lat_data;
        w_burst_cnt  = r_burst_cnt;
        w_wcnt       = r_wcnt;
        w_hold_cnt   = r_hold_cnt;
        w_req_ready  = 1'b0;
        w_resp_valid = 1'b0;
        w_resp_data  = r_resp_data;
        w_dma_out_n  = r_dma_out_n;
        w_addr_o     = r_addr_o;
        w_addr_oe    = r_addr_oe;
        w_rw_n       = r_rw_n;
        w_data_o     = r_data_o;
        w_data_oe    = r_data_oe;

        // Write-data hold countdown runs independently of the bus state
        if (r_hold_cnt != 8'd0) begin
            w_hold_cnt = r_hold_cnt - 8'd1;
            if (r_hold_cnt == 8'd1) begin
                w_data_oe = 1'b0;
            end
        end

        case (r_state)
            S_IDLE: begin
                if (phi1_posedge && req_bus.req_valid && a2_dma_in_n) begin
                    w_req_ready = 1'b1;
                    w_lat_addr  = req_bus.req_addr;
                    w_lat_wr    = req_bus.req_wr;
                    w_lat_data  = req_bus.req_data;
                    w_dma_out_n = 1'b0;
                    w_burst_cnt = 8'd0;
                    w_state     = S_ARM;
                end
            end
            S_ARM: begin
                // A coincident phi1 rise takes priority over phi0 rise
                if (phi1_negedge && !phi1_posedge) begin
                    w_addr_oe = 1'b1;
                    w_addr_o  = r_lat_addr;
                    w_rw_n    = !r_lat_wr;
                    w_wcnt    = 8'd0;
                    w_state   = S_CYCLE;
                end
            end
            S_CYCLE: begin
                if (phi1_posedge && !w_stall) begin
                    w_resp_valid = 1'b1;
                    if (!r_lat_wr) begin
                        w_resp_data = a2_d_i;
                    end
                    w_burst_cnt = r_burst_cnt + 8'd1;
                    if (r_data_oe) begin
                        if (c_wr_hold == 8'd0) begin
                            w_data_oe = 1'b0;
                        end else begin
                            w_hold_cnt = c_wr_hold;
                        end
                    end
                    if (req_bus.req_valid && w_burst_more) begin
                        w_req_ready = 1'b1;
                        w_lat_addr  = req_bus.req_addr;
                        w_lat_wr    = req_bus.req_wr;
                        w_lat_data  = req_bus.req_data;
                        w_state     = S_ARM;
                    end else begin
                        w_dma_out_n = 1'b1;
                        w_addr_oe   = 1'b0;
                        w_rw_n      = 1'b1;
                        w_state     = S_RELEASE;
                    end
                end else if (r_lat_wr && (r_wcnt != c_wr_delay)) begin
                    w_wcnt = r_wcnt + 8'd1;
                    if ((r_wcnt + 8'd1) == c_wr_delay) begin
                        w_data_oe = 1'b1;
                        w_data_o  = r_lat_data;
                    end
                end
            end
            S_RELEASE: begin
                if (!w_data_oe) begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_logic) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_lat_addr   <= 16'd0;
            r_lat_wr     <= 1'b0;
            r_lat_data   <= 8'd0;
            r_burst_cnt  <= 8'd0;
            r_wcnt       <= 8'd0;
            r_hold_cnt   <= 8'd0;
            r_req_ready  <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_data  <= 8'd0;
            r_dma_out_n  <= 1'b1;
            r_addr_o     <= 16'd0;
            r_addr_oe    <= 1'b0;
            r_rw_n       <= 1'b1;
            r_data_o     <= 8'd0;
            r_data_oe    <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_lat_addr   <= w_lat_addr;
            r_lat_wr     <= w_lat_wr;
            r_lat_data   <= w_lat_data;
            r_burst_cnt  <= w_burst_cnt;
            r_wcnt       <= w_wcnt;
            r_hold_cnt   <= w_hold_cnt;
            r_req_ready  <= w_req_ready;
            r_resp_valid <= w_resp_valid;
            r_resp_data  <= w_resp_data;
            r_dma_out_n  <= w_dma_out_n;
            r_addr_o     <= w_addr_o;
            r_addr_oe    <= w_addr_oe;
            r_rw_n       <= w_rw_n;
            r_data_o     <= w_data_o;
            r_data_oe    <= w_data_oe;
            r_busy       <= (w_state != S_IDLE);
        end
    end

    assign req_bus.req_ready  = r_req_ready;
    assign req_bus.resp_valid = r_resp_valid;
    assign req_bus.resp_data  = r_resp_data;
    assign a2_dma_out_n       = r_dma_out_n;
    assign a2_addr_o          = r_addr_o;
    assign a2_addr_oe         = r_addr_oe;
    assign a2_rw_n_o          = r_rw_n;
    assign a2_data_o          = r_data_o;
    assign a2_data_oe         = r_data_oe;
    assign busy               = r_busy;

endmodule
`default_nettype wire
